// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state codes,
// E-stage operation codes and the divide-by-zero quotient constant.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_op_e;

    localparam int unsigned MD_MAX_WIDTH = 64;

    // Quotient written to LO on divide by zero; truncated to the operand width.
    localparam logic [MD_MAX_WIDTH-1:0] MD_DIV0_LO = '1;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath.
// Holds the 2W+1-bit shift-add accumulator, the W+1-bit restoring-divide
// remainder, the shifting dividend/quotient and the latched result signs.
// Produces the sign-corrected HI/LO result combinationally for the FSM to commit.
// Ports: load (latch operands), step (one iteration), div_op/sgn (op kind at
// load), a/b (operands), cnt (remaining iterations), rest_zero_c (multiplier
// bits still to be consumed are all zero), res_hi_c/res_lo_c (final result).
// MULDIV_EARLY_OUT_EN: aligns the product by cnt when multiply exits early.
module muldiv_datapath
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    cnt,
    output logic             rest_zero_c,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c
);

    localparam int unsigned AW = 2 * WIDTH + 1;

    logic [AW-1:0]      acc;
    logic [WIDTH-1:0]   opnd;     // multiplicand for mult, divisor for div
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic               div_q;
    logic               neg_q;    // negate product / quotient
    logic               neg_r;    // negate remainder
    logic               div0;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     upper_sum;
    logic [AW-1:0]      acc_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   rest;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   r_fix;

    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    // One shift-add multiply iteration; the upper half keeps its carry bit.
    assign upper_sum = acc[0] ? (acc[AW-1:WIDTH] + (WIDTH+1)'(opnd)) : acc[AW-1:WIDTH];
    assign acc_nxt   = {1'b0, upper_sum, acc[WIDTH-1:1]};

    // One restoring-divide iteration; diff MSB is the borrow.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = {1'b0, shifted} - (WIDTH+2)'(opnd);

    // Multiplier bits left after the current step occupy the low cnt bits of acc>>1.
    assign rest        = (acc[WIDTH-1:0] >> 1) & ((WIDTH'(1) << cnt) - WIDTH'(1));
    assign rest_zero_c = !div_q && (rest == '0);

    // Operand latch and iteration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            opnd  <= '0;
            rem   <= '0;
            quo   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (load) begin
            acc   <= AW'(b_mag);
            opnd  <= div_op ? b_mag : a_mag;
            rem   <= '0;
            quo   <= a_mag;
            div_q <= div_op;
            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn && a[WIDTH-1];
            div0  <= div_op && (b == '0);
        end else if (step) begin
            if (div_q) begin
                if (diff[WIDTH+1]) begin
                    rem <= shifted;
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end else begin
                    rem <= diff[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc <= acc_nxt;
            end
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Skipped iterations would only have shifted right; do them all at once.
    assign prod = acc[2*WIDTH-1:0] >> cnt;
`else
    assign prod = acc[2*WIDTH-1:0];
`endif

    // Sign correction; divide by zero forces the all-ones quotient.
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = div0 ? WIDTH'(MD_DIV0_LO) : (neg_q ? -quo : quo);
    assign r_mag    = WIDTH'(rem);
    assign r_fix    = neg_r ? -r_mag : r_mag;

    assign res_hi_c = div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo_c = div_q ? q_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, issued from the E stage.
// Ports: clk, reset_n (async active-low); sig_md_op_e/sig_signed_e select
// mult/div and signedness; sig_mthi_e/sig_mtlo_e write src_a_e to HI/LO;
// flush_e masks all E-stage inputs; src_a_e/src_b_e operands; sig_hilo_d flags
// a HI/LO user in D. Outputs hi, lo, busy (op in flight) and stall_md_d
// (busy && sig_hilo_d, combinational).
// MULDIV_EARLY_OUT_EN: multiply leaves RUN once remaining multiplier bits are 0.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       sig_md_op_e,
    input  logic             sig_signed_e,
    input  logic             sig_mthi_e,
    input  logic             sig_mtlo_e,
    input  logic             flush_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             sig_hilo_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_md_d
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             start_c;
    logic             load_c;
    logic             step_c;
    logic             fix_c;
    logic             run_done_c;
    logic             mthi_c;
    logic             mtlo_c;
    logic             rest_zero_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    muldiv_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load_c),
        .step        (step_c),
        .div_op      (sig_md_op_e == MD_DIV),
        .sgn         (sig_signed_e),
        .a           (src_a_e),
        .b           (src_b_e),
        .cnt         (cnt),
        .rest_zero_c (rest_zero_c),
        .res_hi_c    (res_hi_c),
        .res_lo_c    (res_lo_c)
    );

    // State, counter and busy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt != MD_IDLE);
        end
    end

    // Next state and datapath strobes; mt writes lose to a simultaneous start.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_c     = 1'b0;
        step_c     = 1'b0;
        fix_c      = 1'b0;
        start_c    = ((sig_md_op_e == MD_MULT) || (sig_md_op_e == MD_DIV)) && !flush_e;
        run_done_c = (cnt == '0) || (EARLY_OUT && rest_zero_c);
        mthi_c     = (state == MD_IDLE) && sig_mthi_e && !flush_e && !start_c;
        mtlo_c     = (state == MD_IDLE) && sig_mtlo_e && !flush_e && !start_c;
        case (state)
            MD_IDLE: begin
                if (start_c) begin
                    load_c    = 1'b1;
                    cnt_nxt   = CW'(WIDTH - 1);
                    state_nxt = MD_RUN;
                end
            end
            MD_RUN: begin
                step_c = 1'b1;
                if (run_done_c) begin
                    state_nxt = MD_FIX;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            MD_FIX: begin
                fix_c     = 1'b1;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // HI/LO: committed result in FIX, otherwise direct moves while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_c) begin
            hi <= res_hi_c;
            lo <= res_lo_c;
        end else begin
            if (mthi_c) hi <= src_a_e;
            if (mtlo_c) lo <= src_a_e;
        end
    end

    assign stall_md_d = busy && sig_hilo_d;

endmodule
